// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared req/ack
// memory port, with the register file, IR, operand latches and PC held inside the core.
module multi_cycle_cpu #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                REG_NUM  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halt_o
);
    localparam int RW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_ADD = 6'h20, FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0]        pc;
    logic [31:0]              ir_p0;
    logic signed [DATA_W-1:0] a_p1, b_p1, imm_p1, alu_p2, mdr_p3;
    logic [DATA_W-1:0]        regs [REG_NUM];
    logic                     req, we;

    logic [5:0]    op, funct;
    logic [4:0]    shamt;
    logic [RW-1:0] rs, rt, rd, dest;
    logic          is_r, is_j, is_lw, is_sw, legal, br_taken;
    logic [ADDR_W-1:0] j_target;

    function automatic logic op_legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OP_RTYPE: return f inside {FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic zext);
        return zext ? {{(DATA_W-16){1'b0}}, imm} : {{(DATA_W-16){imm[15]}}, imm};
    endfunction

    function automatic logic signed [DATA_W-1:0] alu_op(
        input logic [5:0]               o,
        input logic [5:0]               f,
        input logic [4:0]               sh,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] imm
    );
        logic signed [DATA_W-1:0] r;
        case (o)
            OP_RTYPE: begin
                case (f)
                    FN_ADD:  r = a + b;
                    FN_SUB:  r = a - b;
                    FN_AND:  r = a & b;
                    FN_OR:   r = a | b;
                    FN_SLT:  r = {{(DATA_W-1){1'b0}}, (a < b)};
                    FN_SLL:  r = b << sh;
                    default: r = '0;
                endcase
            end
            OP_SLTI: r = {{(DATA_W-1){1'b0}}, (a < imm)};
            OP_ANDI: r = a & imm;
            OP_ORI:  r = a | imm;
            default: r = a + imm;  // addi and the lw/sw effective address
        endcase
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] x);
        return {x[ADDR_W-1:2], 2'b00};
    endfunction

    assign op    = ir_p0[31:26];
    assign rs    = ir_p0[21 +: RW];
    assign rt    = ir_p0[16 +: RW];
    assign rd    = ir_p0[11 +: RW];
    assign shamt = ir_p0[10:6];
    assign funct = ir_p0[5:0];

    assign is_r     = (op == OP_RTYPE);
    assign is_j     = (op == OP_J);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign legal    = op_legal(op, funct);
    assign dest     = is_r ? rd : rt;
    assign br_taken = ((op == OP_BEQ) && (a_p1 == b_p1)) || ((op == OP_BNE) && (a_p1 != b_p1));
    assign j_target = ((pc >> 28) << 28) | ADDR_W'({ir_p0[25:0], 2'b00});

    // Bus outputs are gated by reset so an in-flight request drops the instant reset asserts.
    assign mem_req_o   = req & rst_i;
    assign mem_we_o    = we & rst_i;
    assign mem_addr_o  = !mem_req_o ? '0 :
                         (state == S_MEM) ? word_addr(ADDR_W'($unsigned(alu_p2))) : word_addr(pc);
    assign mem_wdata_o = mem_we_o ? $unsigned(b_p1) : '0;
    assign pc_o        = pc;
    assign halt_o      = (state == S_HALT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        req        = 1'b0;
        we         = 1'b0;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ack_i) next_state = S_DECODE;
            end
            S_DECODE: begin
                if (!legal)    next_state = S_HALT;
                else if (is_j) next_state = S_FETCH;
                else           next_state = S_EXEC;
            end
            S_EXEC: begin
                if ((op == OP_BEQ) || (op == OP_BNE)) next_state = S_FETCH;
                else if (is_lw || is_sw)             next_state = S_MEM;
                else                                 next_state = S_WB;
            end
            S_MEM: begin
                req = 1'b1;
                we  = is_sw;
                if (mem_ack_i) next_state = is_sw ? S_FETCH : S_WB;
            end
            S_WB:    next_state = S_FETCH;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_HALT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc     <= RESET_PC;
            ir_p0  <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
            imm_p1 <= '0;
            alu_p2 <= '0;
            mdr_p3 <= '0;
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else begin
            case (state)
                // fetch: latch instruction, advance PC
                S_FETCH: begin
                    if (mem_ack_i) begin
                        ir_p0 <= mem_rdata_i[31:0];
                        pc    <= pc + ADDR_W'(4);
                    end
                end
                // decode: operand read, immediate extension, jump resolution
                S_DECODE: begin
                    a_p1   <= regs[rs];
                    b_p1   <= regs[rt];
                    imm_p1 <= ext_imm(ir_p0[15:0], (op == OP_ANDI) || (op == OP_ORI));
                    if (is_j) pc <= j_target;
                end
                // execute: ALU result, branch resolution relative to the already-advanced PC
                S_EXEC: begin
                    alu_p2 <= alu_op(op, funct, shamt, a_p1, b_p1, imm_p1);
                    if (br_taken) pc <= pc + ADDR_W'($unsigned(imm_p1 <<< 2));
                end
                // memory: load data capture
                S_MEM: begin
                    if (mem_ack_i && is_lw) mdr_p3 <= mem_rdata_i;
                end
                // writeback
                S_WB: begin
                    if (dest != '0) regs[dest] <= is_lw ? mdr_p3 : alu_p2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: directed programs plus random programs, compared against an
// instruction-level interpreter; memory responder inserts fixed or random wait states.
module tb_multi_cycle_cpu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ack, halt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    multi_cycle_cpu #(
        .DATA_W(32), .ADDR_W(32), .REG_NUM(32), .RESET_PC(32'h0)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .pc_o(pc), .halt_o(halt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] HALT_INS = {6'h3F, 26'd0};

    int n_checks = 0;
    int n_err = 0;

    logic [31:0] mem   [256];
    logic [31:0] m_mem [256];
    logic [31:0] img   [256];
    logic [31:0] m_r   [32];

    bit          busy, rand_wait, force_ack;
    int          cnt, tgt, max_wait, total_waits, last_cyc;
    logic [31:0] st_addr, st_wdata, last_waddr, last_wdata;
    logic        st_we;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [5:0] pick_fn(input int j);
        case (j)
            0: return 6'h20;
            1: return 6'h22;
            2: return 6'h24;
            3: return 6'h25;
            4: return 6'h2A;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [5:0] pick_iop(input int j);
        case (j)
            0: return 6'h08;
            1: return 6'h0A;
            2: return 6'h0C;
            default: return 6'h0D;
        endcase
    endfunction

    // Memory responder: wait states counted per transfer, data driven on the falling edge.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
                mem_ack = force_ack;
                mem_rdata = force_ack ? 32'hFFFF_FFFF : 32'h0;
            end else if (!mem_req) begin
                busy = 1'b0;
                mem_ack = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    tgt = rand_wait ? $urandom_range(0, max_wait) : max_wait;
                    total_waits += tgt;
                    st_addr = mem_addr;
                    st_we = mem_we;
                    st_wdata = mem_wdata;
                end
                if (cnt == tgt) begin
                    busy = 1'b0;
                    mem_ack = 1'b1;
                    check_val("bus_addr_aligned", {30'd0, mem_addr[1:0]}, 0);
                    if (tgt > 0) begin
                        check_val("bus_addr_stable", mem_addr, st_addr);
                        check_val("bus_we_stable", mem_we, st_we);
                        check_val("bus_wdata_stable", mem_wdata, st_wdata);
                    end
                    if (mem_we) begin
                        mem[mem_addr[9:2]] = mem_wdata;
                        last_waddr = mem_addr;
                        last_wdata = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr[9:2]];
                    end
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    // Instruction-set interpreter: architectural state plus zero-wait cycle cost per instruction.
    task automatic model_run(output int cyc, output logic [31:0] pc_end);
        logic [31:0] mpc, ins, a, b, sx, zx, ea, res;
        logic [4:0]  rs, rt, rd, sh, wreg;
        logic [5:0]  op, fn;
        bit          done, wr;
        int          steps;
        for (int i = 0; i < 32; i++) m_r[i] = '0;
        mpc = 0; cyc = 0; done = 0; steps = 0;
        while (!done && steps < 4000) begin
            steps++;
            ins = m_mem[mpc[9:2]];
            mpc = mpc + 4;
            {op, rs, rt, rd, sh, fn} = ins;
            a = m_r[rs]; b = m_r[rt];
            sx = {{16{ins[15]}}, ins[15:0]};
            zx = {16'h0, ins[15:0]};
            ea = (a + sx) & 32'hFFFF_FFFC;
            wr = 0; wreg = rt; res = 0;
            case (op)
                6'h00: begin
                    wr = 1; wreg = rd; cyc += 4;
                    case (fn)
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h00: res = b << sh;
                        default: begin wr = 0; done = 1; cyc -= 2; end
                    endcase
                end
                6'h08: begin wr = 1; res = a + sx; cyc += 4; end
                6'h0A: begin wr = 1; res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; cyc += 4; end
                6'h0C: begin wr = 1; res = a & zx; cyc += 4; end
                6'h0D: begin wr = 1; res = a | zx; cyc += 4; end
                6'h23: begin wr = 1; res = m_mem[ea[9:2]]; cyc += 5; end
                6'h2B: begin m_mem[ea[9:2]] = b; cyc += 4; end
                6'h04: begin if (a == b) mpc = mpc + (sx << 2); cyc += 3; end
                6'h05: begin if (a != b) mpc = mpc + (sx << 2); cyc += 3; end
                6'h02: begin mpc = {mpc[31:28], ins[25:0], 2'b00}; cyc += 2; end
                default: begin done = 1; cyc += 2; end
            endcase
            if (wr && wreg != 0) m_r[wreg] = res;
        end
        pc_end = mpc;
    endtask

    task automatic clear_image();
        for (int i = 0; i < 256; i++) img[i] = (i < 128) ? HALT_INS : $urandom;
    endtask

    task automatic load_image();
        for (int i = 0; i < 256; i++) begin
            mem[i] = img[i];
            m_mem[i] = img[i];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req", mem_req, 0);
        check_val("rst_we", mem_we, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        check_val("rst_pc", pc, 0);
        check_val("rst_halt", halt, 0);
        @(posedge clk);
        #2;
        total_waits = 0;
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input string tag, input int maxw, input bit rnd);
        int          exp_cyc, cyc;
        logic [31:0] exp_pc;
        max_wait = maxw;
        rand_wait = rnd;
        model_run(exp_cyc, exp_pc);
        do_reset();
        cyc = 0;
        while (!halt && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        last_cyc = cyc;
        check_val({tag, "_halted"}, halt, 1);
        check_val({tag, "_cycles"}, cyc, exp_cyc + total_waits);
        check_val({tag, "_pc"}, pc, exp_pc);
        for (int i = 1; i < 32; i++) check_val({tag, "_reg"}, dut.regs[i], m_r[i]);
        for (int i = 0; i < 256; i++) check_val({tag, "_mem"}, mem[i], m_mem[i]);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_val({tag, "_halt_no_req"}, mem_req, 0);
            check_val({tag, "_halt_hold"}, halt, 1);
        end
    endtask

    task automatic gen_random(input int n);
        int          k, off;
        logic [4:0]  ra, rb, rc;
        logic [15:0] im;
        clear_image();
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rc = 5'($urandom_range(0, 7));
            off = $urandom_range(0, 2);
            im = 16'h200 + 16'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            case (k)
                0, 1, 2: img[i] = enc_r(pick_fn($urandom_range(0, 5)), rc, ra, rb, 5'($urandom_range(0, 31)));
                3, 4:    img[i] = enc_i(pick_iop($urandom_range(0, 3)), rb, ra, 16'($urandom));
                5:       img[i] = enc_i(6'h23, rb, 5'd0, im);
                6:       img[i] = enc_i(6'h2B, rb, 5'd0, im);
                7:       img[i] = enc_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rb, ra, 16'(off));
                8:       img[i] = {6'h02, 26'(i + 1 + off)};
                default: img[i] = enc_i(6'h08, rb, 5'd0, 16'($urandom_range(0, 3)));
            endcase
        end
    endtask

    task automatic image_basic();
        clear_image();
        img[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
        img[1] = enc_i(6'h08, 5'd2, 5'd0, 16'hFFFD);
        img[2] = enc_r(6'h20, 5'd3, 5'd1, 5'd2, 5'd0);
    endtask

    initial begin
        force_ack = 1'b0;
        rand_wait = 1'b0;
        max_wait = 0;
        total_waits = 0;
        last_waddr = '0;
        last_wdata = '0;

        image_basic();
        load_image();
        run_prog("t1", 0, 1'b0);
        check_val("t1_r3", dut.regs[3], 32'd2);
        check_val("t1_total_cycles", last_cyc, 14);

        load_image();
        run_prog("t2", 3, 1'b0);
        check_val("t2_r3", dut.regs[3], 32'd2);
        check_val("t2_total_cycles", last_cyc, 26);

        image_basic();
        img[3] = enc_i(6'h2B, 5'd3, 5'd0, 16'd8);
        img[4] = enc_i(6'h23, 5'd4, 5'd0, 16'd8);
        load_image();
        run_prog("t3", 0, 1'b0);
        check_val("t3_waddr", last_waddr, 32'd8);
        check_val("t3_wdata", last_wdata, 32'd2);
        check_val("t3_r4", dut.regs[4], 32'd2);
        check_val("t3_total_cycles", last_cyc, 23);

        clear_image();
        load_image();
        run_prog("t5_opcode", 0, 1'b0);
        check_val("t5_opcode_cycles", last_cyc, 2);

        clear_image();
        img[0] = enc_r(6'h3F, 5'd1, 5'd1, 5'd1, 5'd0);
        load_image();
        run_prog("t5_funct", 1, 1'b0);
        check_val("t5_funct_cycles", last_cyc, 3);

        clear_image();
        img[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd1);
        img[1] = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
        img[2] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        load_image();
        max_wait = 0;
        rand_wait = 1'b0;
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (c == 7) check_val("t4_bne_not_taken_pc", pc, 32'd8);
            if (c > 7 && (c - 7) % 3 == 0) check_val("t4_loop_pc", pc, 32'd8);
            if (c > 7 && (c - 8) % 3 == 0) check_val("t4_loop_fetch_pc", pc, 32'd12);
        end
        check_val("t4_no_halt", halt, 0);

        image_basic();
        load_image();
        max_wait = 10;
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("t6_req_pending", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check_val("t6_req_drop", mem_req, 0);
        check_val("t6_addr_drop", mem_addr, 0);
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("t6_pc_in_reset", pc, 0);
        check_val("t6_req_in_reset", mem_req, 0);
        check_val("t6_halt_in_reset", halt, 0);
        force_ack = 1'b0;
        run_prog("t6", 0, 1'b0);
        check_val("t6_r3", dut.regs[3], 32'd2);
        check_val("t6_total_cycles", last_cyc, 14);

        for (int r = 0; r < 8; r++) begin
            gen_random(24);
            load_image();
            run_prog("rand", r % 4, (r % 2) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
